// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if -- handshake/data bundle between a byte producer, the
// transmit FIFO and the UART transmitter that drains it.
//
// Signals:
//   fifo_write_n  write strobe, active-low, one word per cycle
//   data_in       write data, sampled while fifo_write_n = 0
//   fifo_read_n   read strobe, active-low (transmitter's fifo_read_tx)
//   data_out      registered read data (transmitter's tx_dout_reg)
//   fifo_empty    stored count = 0
//   fifo_full     stored count = depth
//   ovf_clr       clears the sticky overflow flag   (UART_TXFIFO_OVERFLOW_EN only)
//   overflow      sticky dropped-write flag         (UART_TXFIFO_OVERFLOW_EN only)
//
// Modports: master = producer/transmitter side, slave = FIFO side.
interface uart_tx_fifo_if #(
  parameter int WIDTH = 8
);
  logic             fifo_write_n;
  logic [WIDTH-1:0] data_in;
  logic             fifo_read_n;
  logic [WIDTH-1:0] data_out;
  logic             fifo_empty;
  logic             fifo_full;
`ifdef UART_TXFIFO_OVERFLOW_EN
  logic             ovf_clr;
  logic             overflow;
`endif

  modport master (
    output fifo_write_n, data_in, fifo_read_n,
`ifdef UART_TXFIFO_OVERFLOW_EN
    output ovf_clr,
    input  overflow,
`endif
    input  data_out, fifo_empty, fifo_full
  );

  modport slave (
    input  fifo_write_n, data_in, fifo_read_n,
`ifdef UART_TXFIFO_OVERFLOW_EN
    input  ovf_clr,
    output overflow,
`endif
    output data_out, fifo_empty, fifo_full
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo -- synchronous transmit FIFO of 2^DEPTH_LOG2 words feeding a
// UART transmitter. Read data is registered: data_out updates on the edge
// that accepts a read and then holds until the next accepted read.
// Empty/full flags are decoded from the registered count, so they follow an
// operation one cycle after it is accepted. There is no fall-through: a
// write and read together on an empty FIFO accept only the write.
//
// Ports:
//   clk      system clock, rising edge
//   reset_n  synchronous active-low reset (clears pointers, count, data_out,
//            overflow; storage array is not cleared)
//   bus      uart_tx_fifo_if.slave (strobes, data, flags)
//
// Optional feature: define UART_TXFIFO_OVERFLOW_EN to add the sticky
// overflow flag (bus.overflow) and its clear input (bus.ovf_clr).
module uart_tx_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  uart_tx_fifo_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic [WIDTH-1:0]      dout;

  logic empty;
  logic full;
  logic rd_acc;
  logic wr_acc;
  logic wr_drop;

  // Request qualification from the registered count
  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign rd_acc  = !bus.fifo_read_n && !empty;
  // A full FIFO still takes a write when a read frees a slot on the same edge.
  assign wr_acc  = !bus.fifo_write_n && (!full || rd_acc);
  assign wr_drop = !bus.fifo_write_n && !wr_acc;

  // Storage: no reset, but a write coinciding with reset is suppressed
  always_ff @(posedge clk) begin
    if (reset_n && wr_acc) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  // Pointers, count and registered read data
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign bus.data_out   = dout;
  assign bus.fifo_empty = empty;
  assign bus.fifo_full  = full;

`ifdef UART_TXFIFO_OVERFLOW_EN
  logic ovf;

  // Sticky overflow: a dropped write wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ovf <= 1'b0;
    end else if (wr_drop) begin
      ovf <= 1'b1;
    end else if (bus.ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  assign bus.overflow = ovf;
`else
  logic unused_drop;
  assign unused_drop = wr_drop;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  uart_tx_fifo_if #(.WIDTH(8)) bus ();

  uart_tx_fifo #(.WIDTH(8), .DEPTH_LOG2(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Reference model: a plain queue of stored bytes plus the last value read.
  logic [7:0] q[$];
  logic [7:0] exp_dout;
  logic       exp_ovf;

  // Drive one cycle of strobes, advance the model, return #1 after the edge
  // with strobes released.
  task automatic step(input bit wr, input logic [7:0] din, input bit rd, input bit clr);
    bit rd_ok;
    bit wr_ok;
    bus.fifo_write_n = !wr;
    bus.data_in      = din;
    bus.fifo_read_n  = !rd;
`ifdef UART_TXFIFO_OVERFLOW_EN
    bus.ovf_clr      = clr;
`endif
    @(posedge clk);
    rd_ok = rd && (q.size() > 0);
    wr_ok = wr && ((q.size() < 16) || rd_ok);
    if (!reset_n) begin
      q.delete();
      exp_dout = 8'h00;
      exp_ovf  = 1'b0;
    end else begin
      if (rd_ok) exp_dout = q.pop_front();
      if (wr_ok) q.push_back(din);
      if (wr && !wr_ok) exp_ovf = 1'b1;
      else if (clr) exp_ovf = 1'b0;
    end
    #1;
    bus.fifo_write_n = 1'b1;
    bus.fifo_read_n  = 1'b1;
`ifdef UART_TXFIFO_OVERFLOW_EN
    bus.ovf_clr      = 1'b0;
`endif
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", bus.fifo_empty); end
    checks++; if (bus.fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", bus.fifo_full); end
    checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", bus.data_out); end
  endtask

  task automatic test_single();
    step(1, 8'hA5, 0, 0);
    checks++; if (bus.fifo_empty !== 1'b0) begin errors++; $display("FAIL single_not_empty: got %b expected 0", bus.fifo_empty); end
    step(0, 8'h00, 1, 0);
    checks++; if (bus.data_out !== 8'hA5) begin errors++; $display("FAIL single_dout: got %h expected a5", bus.data_out); end
    checks++; if (bus.fifo_empty !== 1'b1) begin errors++; $display("FAIL single_empty: got %b expected 1", bus.fifo_empty); end
    // Read while empty must leave data_out alone
    step(0, 8'h00, 1, 0);
    checks++; if (bus.data_out !== 8'hA5) begin errors++; $display("FAIL empty_read_hold: got %h expected a5", bus.data_out); end
  endtask

  task automatic test_fill_drop();
    for (int i = 0; i < 16; i++) begin
      step(1, 8'(i), 0, 0);
      checks++;
      if (bus.fifo_full !== (i == 15)) begin errors++; $display("FAIL fill_full[%0d]: got %b expected %b", i, bus.fifo_full, (i == 15)); end
    end
    step(1, 8'hFF, 0, 0);
    checks++; if (bus.fifo_full !== 1'b1) begin errors++; $display("FAIL drop_full: got %b expected 1", bus.fifo_full); end
    for (int i = 0; i < 16; i++) begin
      step(0, 8'h00, 1, 0);
      checks++;
      if (bus.data_out !== 8'(i)) begin errors++; $display("FAIL drain_dout[%0d]: got %h expected %h", i, bus.data_out, 8'(i)); end
    end
    checks++; if (bus.fifo_empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b expected 1", bus.fifo_empty); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0);
    step(1, 8'h55, 1, 0);
    checks++; if (bus.fifo_full !== 1'b1) begin errors++; $display("FAIL simfull_full: got %b expected 1", bus.fifo_full); end
    checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL simfull_dout: got %h expected 00", bus.data_out); end
    for (int i = 1; i <= 16; i++) begin
      step(0, 8'h00, 1, 0);
      checks++;
      if (bus.data_out !== ((i == 16) ? 8'h55 : 8'(i))) begin errors++; $display("FAIL simfull_read[%0d]: got %h expected %h", i, bus.data_out, ((i == 16) ? 8'h55 : 8'(i))); end
    end
    checks++; if (bus.fifo_empty !== 1'b1) begin errors++; $display("FAIL simfull_empty: got %b expected 1", bus.fifo_empty); end
    step(1, 8'h3C, 1, 0);
    checks++; if (bus.data_out !== 8'h55) begin errors++; $display("FAIL simempty_hold: got %h expected 55", bus.data_out); end
    checks++; if (bus.fifo_empty !== 1'b0) begin errors++; $display("FAIL simempty_flag: got %b expected 0", bus.fifo_empty); end
    step(0, 8'h00, 1, 0);
    checks++; if (bus.data_out !== 8'h3C) begin errors++; $display("FAIL simempty_read: got %h expected 3c", bus.data_out); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 40; i++) begin
      step(1, 8'(8'h70 + i), 0, 0);
      step(0, 8'h00, 1, 0);
      checks++;
      if (bus.data_out !== 8'(8'h70 + i)) begin errors++; $display("FAIL wrap_dout[%0d]: got %h expected %h", i, bus.data_out, 8'(8'h70 + i)); end
      checks++;
      if (bus.fifo_empty !== 1'b1) begin errors++; $display("FAIL wrap_empty[%0d]: got %b expected 1", i, bus.fifo_empty); end
    end
  endtask

  task automatic test_random();
    bit wr;
    bit rd;
    bit clr;
    for (int i = 0; i < 600; i++) begin
      // Alternate write-heavy and read-heavy phases so both flags are visited.
      if ((i / 60) % 2 == 0) begin
        wr = ($urandom_range(0, 9) < 8);
        rd = ($urandom_range(0, 9) < 3);
      end else begin
        wr = ($urandom_range(0, 9) < 3);
        rd = ($urandom_range(0, 9) < 8);
      end
      clr = ($urandom_range(0, 7) == 0);
      step(wr, 8'($urandom), rd, clr);
      checks++;
      if (bus.data_out !== exp_dout) begin errors++; $display("FAIL rand_dout[%0d]: got %h expected %h", i, bus.data_out, exp_dout); end
      checks++;
      if (bus.fifo_empty !== (q.size() == 0)) begin errors++; $display("FAIL rand_empty[%0d]: got %b expected %b", i, bus.fifo_empty, (q.size() == 0)); end
      checks++;
      if (bus.fifo_full !== (q.size() == 16)) begin errors++; $display("FAIL rand_full[%0d]: got %b expected %b", i, bus.fifo_full, (q.size() == 16)); end
`ifdef UART_TXFIFO_OVERFLOW_EN
      checks++;
      if (bus.overflow !== exp_ovf) begin errors++; $display("FAIL rand_ovf[%0d]: got %b expected %b", i, bus.overflow, exp_ovf); end
`endif
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 8'(8'hC0 + i), 0, 0);
    step(0, 8'h00, 1, 0);
    reset_n = 1'b0;
    step(1, 8'hEE, 1, 0);
    reset_n = 1'b1;
    checks++; if (bus.fifo_empty !== 1'b1) begin errors++; $display("FAIL midrst_empty: got %b expected 1", bus.fifo_empty); end
    checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL midrst_dout: got %h expected 00", bus.data_out); end
    step(1, 8'h5A, 0, 0);
    step(0, 8'h00, 1, 0);
    checks++; if (bus.data_out !== 8'h5A) begin errors++; $display("FAIL midrst_read: got %h expected 5a", bus.data_out); end
    checks++; if (bus.fifo_empty !== 1'b1) begin errors++; $display("FAIL midrst_empty2: got %b expected 1", bus.fifo_empty); end
  endtask

`ifdef UART_TXFIFO_OVERFLOW_EN
  task automatic test_overflow();
    do_reset();
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_reset: got %b expected 0", bus.overflow); end
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0);
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_fill: got %b expected 0", bus.overflow); end
    step(1, 8'hFF, 0, 0);
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", bus.overflow); end
    step(0, 8'h00, 0, 0);
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_hold: got %b expected 1", bus.overflow); end
    step(0, 8'h00, 0, 1);
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b expected 0", bus.overflow); end
    step(1, 8'hFE, 0, 1);
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b expected 1", bus.overflow); end
    step(1, 8'h99, 1, 1);
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_no_drop_on_rw: got %b expected 0", bus.overflow); end
  endtask
`endif

  initial begin
    bus.fifo_write_n = 1'b1;
    bus.fifo_read_n  = 1'b1;
    bus.data_in      = 8'h00;
`ifdef UART_TXFIFO_OVERFLOW_EN
    bus.ovf_clr      = 1'b0;
`endif
    exp_dout = 8'h00;
    exp_ovf  = 1'b0;
    test_reset();
    test_single();
    test_fill_drop();
    test_simultaneous();
    test_wrap();
    test_random();
    test_reset_mid_burst();
`ifdef UART_TXFIFO_OVERFLOW_EN
    test_overflow();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits.
REQ-002 SHALL have parameter DEPTH_LOG2, default 4: log2 of storage depth (depth = 2^DEPTH_LOG2 = 16 words).
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port fifo_write_n  input  1  write strobe, active-low, one word per cycle.
REQ-006 SHALL have port data_in  input  WIDTH  write data, sampled when fifo_write_n=0.
REQ-007 SHALL have port fifo_read_n  input  1  read strobe, active-low, driven by the transmitter's fifo_read_tx.
REQ-008 SHALL have port data_out  output  WIDTH  registered read data, feeds the transmitter's tx_dout_reg.
REQ-009 SHALL have port fifo_empty  output  1  high when stored count = 0.
REQ-010 SHALL have port fifo_full  output  1  high when stored count = 2^DEPTH_LOG2.

Function
REQ-011 SHALL hold 2^DEPTH_LOG2 words of WIDTH bits, with a DEPTH_LOG2-bit write pointer, a DEPTH_LOG2-bit read pointer and a (DEPTH_LOG2+1)-bit count register.
REQ-012 SHALL accept a write when fifo_write_n=0 and (fifo_full=0, or a read is accepted in the same cycle): store data_in at the write pointer, then increment the write pointer modulo depth.
REQ-013 SHALL accept a read when fifo_read_n=0 and fifo_empty=0: load data_out with the word at the read pointer on that clock edge, then increment the read pointer modulo depth.
REQ-014 SHALL make data_out valid on the cycle after the accepted read, and SHALL hold it unchanged until the next accepted read.
REQ-015 SHALL give a count of +1 for a write only, -1 for a read only, and no change for both or neither.
REQ-016 SHALL decode fifo_empty and fifo_full directly from the registered count, so flags reflect an operation on the cycle after it is accepted.
REQ-017 SHALL, on a write while full with no accepted read, drop the word and leave pointers, count and contents unchanged.
REQ-018 SHALL, on a read while empty, ignore the read and leave data_out and the pointers unchanged.
REQ-019 SHALL, on a simultaneous write and read while empty, accept only the write (no fall-through); fifo_empty goes low on the next cycle.
REQ-020 SHALL, on a simultaneous write and read while full, accept both; fifo_full stays high.
REQ-021 SHALL preserve first-in-first-out order across pointer wrap-around.

Reset
REQ-022 SHALL, when reset_n=0 at a rising clk edge, clear both pointers and the count, set data_out=0, fifo_empty=1 and fifo_full=0, and (with the macro defined) set overflow=0.
REQ-023 SHALL NOT reset the storage array; words present before a reset are unreachable afterwards.
REQ-024 SHALL give reset priority over any simultaneous read or write, including a reset asserted mid-burst.

Configuration
REQ-025 SHALL, with macro UART_TXFIFO_OVERFLOW_EN defined, add port ovf_clr (input, 1, clears the flag) and port overflow (output, 1, sticky flag).
REQ-026 SHALL, with UART_TXFIFO_OVERFLOW_EN defined, set overflow on any write dropped under REQ-017 and clear it when ovf_clr=1; a set SHALL win over a clear in the same cycle.
REQ-027 SHALL, without UART_TXFIFO_OVERFLOW_EN, omit ovf_clr, overflow and their logic; all other behaviour SHALL be identical.

Verification
REQ-028 SHALL cover reset: hold reset_n=0 for 2 clocks -> fifo_empty=1, fifo_full=0, data_out=0x00.
REQ-029 SHALL cover single word: write 0xA5, then pulse fifo_read_n low -> data_out=0xA5 one cycle later, fifo_empty=1.
REQ-030 SHALL cover fill and drop: write 0x00..0x0F -> fifo_full=1; write 0xFF -> dropped; 16 reads -> 0x00..0x0F in order, then fifo_empty=1.
REQ-031 SHALL cover simultaneous operations: when full, read+write 0x55 together -> fifo_full stays 1 and 0x55 is the 16th word read; when empty, read+write 0x3C together -> data_out unchanged, then 0x3C is read.
REQ-032 SHALL cover wrap: 40 write-then-read pairs of an incrementing byte -> each read returns the matching byte and fifo_empty=1 after each pair.
REQ-033 SHALL cover overflow with UART_TXFIFO_OVERFLOW_EN: write to a full FIFO -> overflow=1 and held; ovf_clr=1 -> overflow=0; ovf_clr=1 with a dropped write in the same cycle -> overflow=1.
